smi_flit_scale_d4: RTL

- Width-reduction counterpart of the x4 flit scaler.
- Accepts SMI flits of FlitWidth*4 bytes and serialises each into one to four SMI flits of FlitWidth bytes, lowest byte lanes first.
- Sits on the return path, downstream of wide-datapath logic, and feeds narrow SMI links or the x4 scaler's input side.
- End-of-frame (eofc) byte counts are recomputed per output flit, so a partially filled final wide flit emits only the narrow flits that carry valid bytes.

---
 rtl/smi_flit_scale_d4.sv | 108 ++++++++++
 1 files changed

// File: rtl/smi_flit_scale_d4.sv
// Serialises one wide SMI flit (4*FlitWidth bytes) into 1..4 narrow flits, low byte lanes first.
// The end-of-frame byte count is recomputed for each narrow flit; empty trailing segments are skipped.

module smi_flit_scale_d4_lane (
  input  logic [1:0]      seg_idx,
  input  logic [3:0][7:0] seg_bytes,
  output logic [7:0]      lane_byte
);
  assign lane_byte = seg_bytes[seg_idx];
endmodule

module smi_flit_scale_d4 #(
  parameter int FlitWidth = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*32-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutReady,
  output logic [7:0]             smiOutEofc,
  output logic [FlitWidth*8-1:0] smiOutData,
  input  logic                   smiOutStop
);
  localparam int InW      = FlitWidth * 32;
  localparam int MaxE     = FlitWidth * 4;
  localparam int SegShift = $clog2(FlitWidth);

  logic           hold_valid_q, hold_valid_d;
  logic [InW-1:0] hold_data_q,  hold_data_d;
  logic [8:0]     hold_eofc_q,  hold_eofc_d;
  logic [1:0]     seg_idx_q,    seg_idx_d;
  logic [1:0]     last_seg_q,   last_seg_d;

  logic       in_xfer, out_xfer, on_last;
  logic [8:0] in_eofc_ext, in_e_sat, in_e_m1, out_rem;
  logic [1:0] in_last_seg;

  // Saturated byte count and final segment index of the incoming flit
  always_comb begin
    in_eofc_ext = {1'b0, smiInEofc};
    in_e_sat    = (in_eofc_ext > 9'(MaxE)) ? 9'(MaxE) : in_eofc_ext;
    in_e_m1     = in_e_sat - 9'd1;
    in_last_seg = (in_e_sat == 9'd0) ? 2'd3 : 2'(in_e_m1 >> SegShift);
  end

  assign on_last   = (seg_idx_q == last_seg_q);
  assign out_xfer  = hold_valid_q & ~smiOutStop;
  // Refill on the same edge the last segment leaves, so wide flits stream without a bubble.
  assign smiInStop = hold_valid_q & ~(on_last & ~smiOutStop);
  assign in_xfer   = smiInReady & ~smiInStop;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_eofc_d  = hold_eofc_q;
    seg_idx_d    = seg_idx_q;
    last_seg_d   = last_seg_q;
    if (out_xfer && !on_last) begin
      seg_idx_d = seg_idx_q + 2'd1;
    end else if (in_xfer) begin
      hold_valid_d = 1'b1;
      hold_data_d  = smiInData;
      hold_eofc_d  = in_e_sat;
      seg_idx_d    = 2'd0;
      last_seg_d   = in_last_seg;
    end else if (out_xfer) begin
      hold_valid_d = 1'b0;
      seg_idx_d    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_eofc_q  <= '0;
      seg_idx_q    <= '0;
      last_seg_q   <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_eofc_q  <= hold_eofc_d;
      seg_idx_q    <= seg_idx_d;
      last_seg_q   <= last_seg_d;
    end
  end

  genvar gl, gs;
  generate
    for (gl = 0; gl < FlitWidth; gl++) begin : g_lane
      logic [3:0][7:0] seg_bytes;
      for (gs = 0; gs < 4; gs++) begin : g_seg
        assign seg_bytes[gs] = hold_data_q[(gs*FlitWidth+gl)*8 +: 8];
      end
      smi_flit_scale_d4_lane u_lane (
        .seg_idx   (seg_idx_q),
        .seg_bytes (seg_bytes),
        .lane_byte (smiOutData[gl*8 +: 8])
      );
    end
  endgenerate

  assign out_rem     = hold_eofc_q - ({7'd0, last_seg_q} << SegShift);
  assign smiOutReady = hold_valid_q;
  assign smiOutEofc  = (hold_eofc_q == 9'd0 || seg_idx_q < last_seg_q) ? 8'd0 : out_rem[7:0];
endmodule
